// File: rtl/rsa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rsa_pkg
//  Description : Shared types and helpers for the RSA decoder front-end:
//                sequencer state encoding, default word width and modulus,
//                and the modulus range check used on every ciphertext word.
//  Revision    : 1.0 - initial release
// ============================================================================
package rsa_pkg;

    localparam int          K_DEFAULT = 12;
    localparam logic [11:0] N_DEFAULT = 12'd3551;

    // Sequencer state encodings
    localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
    localparam logic [1:0] ST_ISSUE_ENC  = 2'd1;
    localparam logic [1:0] ST_OUTPUT_ENC = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE_ENC,
        ISSUE  = ST_ISSUE_ENC,
        OUTPUT = ST_OUTPUT_ENC
    } seq_state_t;

    // A word is decodable only if it is strictly below the modulus.
    function automatic logic word_in_range(input logic [31:0] word,
                                           input logic [31:0] modulus);
        return (word < modulus);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rsa_seq_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rsa_seq_fifo
//  Description : Small synchronous FIFO with asynchronous active-low reset.
//                Pointers wrap naturally at DEPTH (a power of two). Read data
//                comes straight from the storage flops at the read pointer,
//                so the head word is valid the cycle after it was written.
//  Revision    : 1.0 - initial release
// ============================================================================
module rsa_seq_fifo #(
    parameter int DEPTH     = 4,
    parameter int LOG_DEPTH = 2,
    parameter int WIDTH     = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_push,
    input  logic [WIDTH-1:0]     i_wdata,
    input  logic                 i_pop,
    output logic [WIDTH-1:0]     o_rdata,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [LOG_DEPTH:0]   o_count
);

    localparam int CNT_W = LOG_DEPTH + 1;

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [WIDTH-1:0]     mem_d [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 w_push;
    logic                 w_pop;

    // Elaboration guard: pointer wrap only works for power-of-two depths
    if ((1 << LOG_DEPTH) != DEPTH) begin : g_bad_depth
        $error("rsa_seq_fifo: DEPTH must equal 2**LOG_DEPTH");
    end

    assign o_full  = (count_q == CNT_W'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_rdata = mem_q[rd_ptr_q];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
        if (w_push) begin
            mem_d[wr_ptr_q] = i_wdata;
            wr_ptr_d        = wr_ptr_q + LOG_DEPTH'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + LOG_DEPTH'(1);
        end
    end

    // FIFO state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rsa_dec_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rsa_dec_sequencer
//  Description : Stream front-end for rsa_decoder. Buffers ciphertext words,
//                range-checks each against the modulus, drives the decoder's
//                level start/done handshake and returns one result per word,
//                in order, on a valid/ready output. Out-of-range words bypass
//                the decoder and come back raw with out_err set.
//                Optional build macro RSA_SEQ_TIMEOUT_EN adds a watchdog that
//                abandons a decode after TIMEOUT cycles and reports an error.
//  Revision    : 1.0 - initial release
// ============================================================================
module rsa_dec_sequencer
    import rsa_pkg::*;
#(
    parameter int           K         = K_DEFAULT,
    parameter logic [K-1:0] N         = K'(N_DEFAULT),
    parameter int           DEPTH     = 4,
    parameter int           LOG_DEPTH = 2,
    parameter int           TIMEOUT   = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [K-1:0] in_data,
    output logic         dec_start,
    output logic [K-1:0] dec_data_in,
    input  logic [K-1:0] dec_data_out,
    input  logic         dec_done,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [K-1:0] out_data,
    output logic         out_err,
    output logic         busy
);

    localparam int CNT_W = LOG_DEPTH + 1;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("rsa_dec_sequencer: TIMEOUT must be at least 1");
    end

    seq_state_t       state_q, state_d;
    logic             dec_start_q, dec_start_d;
    logic [K-1:0]     dec_data_in_q, dec_data_in_d;
    logic             out_valid_q, out_valid_d;
    logic [K-1:0]     out_data_q, out_data_d;
    logic             out_err_q, out_err_d;
    logic             busy_q, busy_d;

    logic             w_push;
    logic             w_pop;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [K-1:0]     w_head;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_count_next;
    logic             w_out_fire;

`ifdef RSA_SEQ_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    logic [TMR_W-1:0] timer_q, timer_d;
`endif

    assign in_ready     = !w_fifo_full;
    assign w_push       = in_valid && in_ready;
    assign w_out_fire   = out_valid_q && out_ready;
    assign w_count_next = w_count + CNT_W'(w_push) - CNT_W'(w_pop);

    assign dec_start    = dec_start_q;
    assign dec_data_in  = dec_data_in_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_err      = out_err_q;
    assign busy         = busy_q;

    rsa_seq_fifo #(
        .DEPTH     (DEPTH),
        .LOG_DEPTH (LOG_DEPTH),
        .WIDTH     (K)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (in_data),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_count)
    );

    // Sequencer next-state: pop/range-check, decoder handshake, result hold
    always_comb begin
        state_d       = state_q;
        dec_start_d   = dec_start_q;
        dec_data_in_d = dec_data_in_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_err_d     = out_err_q;
        w_pop         = 1'b0;
`ifdef RSA_SEQ_TIMEOUT_EN
        timer_d       = timer_q;
`endif
        case (state_q)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop = 1'b1;
                    if (word_in_range(32'(w_head), 32'(N))) begin
                        dec_data_in_d = w_head;
                        dec_start_d   = 1'b1;
                        state_d       = ISSUE;
`ifdef RSA_SEQ_TIMEOUT_EN
                        timer_d       = '0;
`endif
                    end else begin
                        // Decoder is never started for an out-of-range word
                        out_data_d  = w_head;
                        out_err_d   = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = OUTPUT;
                    end
                end
            end
            ISSUE: begin
                if (dec_done) begin
                    out_data_d  = dec_data_out;
                    out_err_d   = 1'b0;
                    out_valid_d = 1'b1;
                    dec_start_d = 1'b0;
                    state_d     = OUTPUT;
                end
`ifdef RSA_SEQ_TIMEOUT_EN
                else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    // Watchdog expiry: report the raw word as an error
                    dec_start_d = 1'b0;
                    out_data_d  = dec_data_in_q;
                    out_err_d   = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = OUTPUT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
`endif
            end
            OUTPUT: begin
                if (w_out_fire) begin
                    out_valid_d = 1'b0;
                end
                // Wait for the decoder's done to fall so the next start is
                // seen as a fresh request.
                if ((!out_valid_q || w_out_fire) && !dec_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (w_count_next != '0) || (state_d != IDLE);
    end

    // Sequencer registers; reset drops dec_start and discards results at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            dec_start_q   <= 1'b0;
            dec_data_in_q <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_err_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            dec_start_q   <= dec_start_d;
            dec_data_in_q <= dec_data_in_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_err_q     <= out_err_d;
            busy_q        <= busy_d;
        end
    end

`ifdef RSA_SEQ_TIMEOUT_EN
    // Watchdog counter for the ISSUE state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/rsa_dec_sequencer.md
Name: rsa_dec_sequencer

Overview:
Stream front-end that sits directly upstream of rsa_decoder and feeds it one ciphertext word at a time.
- Accepts ciphertext words on a valid/ready input and buffers them in a small FIFO.
- Range-checks each word against modulus n, drives the decoder's level start/done handshake, and captures each plaintext result.
- Presents results on a valid/ready output, in order, one result per input word.

Parameters:
- n, 12'd3551, RSA modulus; must match the decoder instance.
- k, 12, word width in bits.
- depth, 4, FIFO entries; must be a power of two.
- log_depth, 2, log2(depth).
- timeout, 1024, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, ciphertext word available.
- in_ready, output, 1, FIFO can accept a word.
- in_data, input, k, ciphertext word.
- dec_start, output, 1, to decoder start; level, held until done.
- dec_data_in, output, k, to decoder data_in; stable while dec_start=1.
- dec_data_out, input, k, from decoder data_out.
- dec_done, input, 1, from decoder done.
- out_valid, output, 1, result available.
- out_ready, input, 1, consumer accepts result.
- out_data, output, k, plaintext, or the raw word on error.
- out_err, output, 1, qualifies out_data; 1 means input word >= n (or timeout).
- busy, output, 1, FIFO non-empty or FSM not IDLE.

Behaviour:
- One clock domain, clk. Reset is asynchronous, active-low on rst_n.
- Reset values: in_ready=1, dec_start=0, dec_data_in=0, out_valid=0, out_data=0, out_err=0, busy=0. FIFO pointers, count and FSM state are cleared.
- All outputs are registered. The only exception is in_ready = (count != depth).
- Reset asserted mid-operation aborts everything. dec_start drops asynchronously, and any buffered words and in-flight results are discarded.
- FIFO:
  - Push when in_valid && in_ready. Pop only in IDLE when count != 0.
  - Push and pop in the same cycle are allowed; count is unchanged. When full, no push is possible.
  - Pointers are log_depth bits and wrap naturally.
- FSM states: IDLE, ISSUE, OUTPUT.
- IDLE, FIFO non-empty: pop the head word w.
  - If w < n (unsigned k-bit compare): dec_data_in<=w, dec_start<=1, go to ISSUE.
  - If w >= n: out_data<=w, out_err<=1, out_valid<=1, go to OUTPUT. The decoder is never started for this word.
- ISSUE: hold dec_start=1 and dec_data_in until dec_done=1 is sampled. On that edge:
  - out_data<=dec_data_out, out_err<=0, out_valid<=1, dec_start<=0.
  - Go to OUTPUT.
- OUTPUT:
  - out_valid and out_data stay stable until out_valid && out_ready, after which out_valid<=0.
  - Return to IDLE once out_valid is 0 (or is clearing this edge) and dec_done=0. This keeps dec_start low for at least one cycle and lets the decoder's done fall before the next start.
- Latency: a word pushed at edge t is popped at edge t+1 if the FSM is IDLE, so dec_start=1 after edge t+1. A result captured at edge d gives out_valid=1 after edge d.
- Minimum back-to-back spacing between decoder starts is 2 cycles after the prior done falls.
- Ordering: strictly FIFO order, one result per input word, error words included.

Optional Feature:
- Macro: RSA_SEQ_TIMEOUT_EN.
- When defined:
  - A counter of width clog2(timeout+1) resets on entry to ISSUE and increments every ISSUE cycle.
  - If it reaches timeout without dec_done: dec_start<=0, out_data<=dec_data_in, out_err<=1, out_valid<=1, go to OUTPUT.
  - The OUTPUT exit condition (dec_done=0) still applies.
- When undefined: no counter is built, and ISSUE waits indefinitely.

Decomposition:
- Package rsa_pkg holds:
  - FSM state localparams (IDLE=2'd0, ISSUE=2'd1, OUTPUT=2'd2);
  - default k;
  - a shared function that range-checks a word against n.
- One sub-module, rsa_seq_fifo: parameterised depth/width synchronous FIFO with asynchronous active-low reset, full/empty/count outputs, and registered read data. The top-level module contains the FSM, range check and capture registers.

Test Plan:
- Nominal: push 2959 then 59 with out_ready=1, real rsa_decoder attached (d=1373, exp_2k=2292) -> two outputs in order, out_err=0, out_data equal to the model's c^1373 mod 3551 for each word. dec_start is low at least 1 cycle between the two starts.
- Out of range: push 3551, 4000, then 100 -> first two outputs have out_err=1 and out_data=3551 and 4000. dec_start rises only for word 100, whose result equals the model.
- Fill: decoder stub holds dec_done=0 and in_valid is held high with words 1..8 -> exactly 5 words accepted (1 in flight, 4 buffered), then in_ready=0. Releasing dec_done drains them in order 1..5.
- Back-pressure: out_ready=0 for 20 cycles after out_valid rises -> out_data and out_valid stay stable, and no new dec_start occurs. Setting out_ready=1 completes the transfer in 1 cycle.
- Reset mid-op: assert rst_n=0 while in ISSUE with 3 words buffered -> all outputs return to reset values immediately. After release, busy=0 and no stale output appears.
- Timeout (RSA_SEQ_TIMEOUT_EN, timeout=16): stub never asserts done, push 77 -> 16 cycles after dec_start rises, out_valid=1, out_err=1, out_data=77, and dec_start=0.
